// File: rtl/multdiv_sched_if.sv
// multdiv_sched_if: requester request/response bus plus the shared mult/div unit port.
// Latency: none, wiring only.
// Backpressure: req_valid_i held until req_ready_o; rsp_valid_o held until rsp_ready_i.
interface multdiv_sched_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_div_i;
  logic [63:0] req_a_i;
  logic [63:0] req_b_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [31:0] rsp_hi_o;
  logic [31:0] rsp_lo_o;
  logic [3:0]  mdu_ctl_o;
  logic [31:0] mdu_op1_o;
  logic [31:0] mdu_op2_o;
  logic        mdu_stall_i;
  logic [31:0] mdu_res_i;
  logic        busy_o;

  // Scheduler side.
  modport slave (
    input  req_valid_i, req_div_i, req_a_i, req_b_i, rsp_ready_i, mdu_stall_i, mdu_res_i,
    output req_ready_o, rsp_valid_o, rsp_hi_o, rsp_lo_o, mdu_ctl_o, mdu_op1_o, mdu_op2_o, busy_o
  );

  // Requesters plus the arithmetic unit.
  modport master (
    output req_valid_i, req_div_i, req_a_i, req_b_i, rsp_ready_i, mdu_stall_i, mdu_res_i,
    input  req_ready_o, rsp_valid_o, rsp_hi_o, rsp_lo_o, mdu_ctl_o, mdu_op1_o, mdu_op2_o, busy_o
  );
endinterface

// File: rtl/multdiv_sched.sv
// multdiv_sched: round-robin share of one mult/div unit by two requesters; MULTDIV_SCHED_REUSE_EN adds a one-entry result cache.
// Latency: multiply accept->response MULT_LAT+3 cycles; divide 3 cycles after stall is seen low; cache hit 1 cycle.
// Backpressure: response held until rsp_ready_i; requests arriving while busy wait without req_ready_o.
module multdiv_sched #(
  parameter int unsigned MULT_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  multdiv_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RD_LO, RD_HI, RESP} state_t;

  localparam logic [3:0] CTL_MUL   = 4'b1100;
  localparam logic [3:0] CTL_DIV   = 4'b1101;
  localparam logic [3:0] CTL_RD_LO = 4'b1001;
  localparam logic [3:0] CTL_RD_HI = 4'b1000;
  localparam logic [7:0] WAIT_LAST = 8'(MULT_LAT - 1);

  state_t      state;
  logic        ptr;
  logic        id;
  logic        div_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [7:0]  cnt;
  logic [1:0]  req_ready_q;
  logic [1:0]  rsp_valid_q;
  logic [3:0]  ctl_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        busy_q;

  logic        sel;
  logic        sel_div;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

`ifdef MULTDIV_SCHED_REUSE_EN
  logic        cache_vld;
  logic        cache_div;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [31:0] cache_hi;
  logic [31:0] cache_lo;
  logic        hit_q;
  logic        sel_hit;

  assign sel_hit = cache_vld && (cache_div == sel_div) && (cache_a == sel_a) && (cache_b == sel_b);
`endif

  // Arbitration: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    sel = 1'b0;
    case (bus.req_valid_i)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ptr;
      default: sel = 1'b0;
    endcase
    sel_div = sel ? bus.req_div_i[1]      : bus.req_div_i[0];
    sel_a   = sel ? bus.req_a_i[63:32]    : bus.req_a_i[31:0];
    sel_b   = sel ? bus.req_b_i[63:32]    : bus.req_b_i[31:0];
  end

  // Scheduler FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      id          <= 1'b0;
      div_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt         <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      ctl_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      busy_q      <= 1'b0;
`ifdef MULTDIV_SCHED_REUSE_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid_i) begin
            id          <= sel;
            div_q       <= sel_div;
            a_q         <= sel_a;
            b_q         <= sel_b;
            op1_q       <= sel_a;
            op2_q       <= sel_b;
            req_ready_q <= sel ? 2'b10 : 2'b01;
            busy_q      <= 1'b1;
            state       <= ISSUE;
`ifdef MULTDIV_SCHED_REUSE_EN
            hit_q       <= sel_hit;
            ctl_q       <= sel_hit ? 4'b0000 : (sel_div ? CTL_DIV : CTL_MUL);
`else
            ctl_q       <= sel_div ? CTL_DIV : CTL_MUL;
`endif
          end
        end
        ISSUE: begin
          req_ready_q <= '0;
          ctl_q       <= '0;
`ifdef MULTDIV_SCHED_REUSE_EN
          if (hit_q) begin
            // Identical to the cached operation: answer without touching the unit.
            hi_q        <= cache_hi;
            lo_q        <= cache_lo;
            op1_q       <= '0;
            op2_q       <= '0;
            rsp_valid_q <= id ? 2'b10 : 2'b01;
            state       <= RESP;
          end else begin
            cnt   <= WAIT_LAST;
            state <= WAIT;
          end
`else
          cnt   <= WAIT_LAST;
          state <= WAIT;
`endif
        end
        WAIT: begin
          // Multiply counts a fixed latency; divide waits for the unit to drop stall.
          if (div_q ? !bus.mdu_stall_i : (cnt == 8'd0)) begin
            ctl_q <= CTL_RD_LO;
            state <= RD_LO;
          end else if (!div_q) begin
            cnt <= cnt - 8'd1;
          end
        end
        RD_LO: begin
          lo_q  <= bus.mdu_res_i;
          ctl_q <= CTL_RD_HI;
          state <= RD_HI;
        end
        RD_HI: begin
          hi_q        <= bus.mdu_res_i;
          ctl_q       <= '0;
          op1_q       <= '0;
          op2_q       <= '0;
          rsp_valid_q <= id ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i[id]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ptr         <= ~id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTDIV_SCHED_REUSE_EN
  // Remember the last completed operation at its response handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cache_vld <= 1'b0;
    end else if ((state == RESP) && bus.rsp_ready_i[id]) begin
      cache_vld <= 1'b1;
      cache_div <= div_q;
      cache_a   <= a_q;
      cache_b   <= b_q;
      cache_hi  <= hi_q;
      cache_lo  <= lo_q;
    end
  end
`endif

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_hi_o    = hi_q;
  assign bus.rsp_lo_o    = lo_q;
  assign bus.mdu_ctl_o   = ctl_q;
  assign bus.mdu_op1_o   = op1_q;
  assign bus.mdu_op2_o   = op2_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: directed vectors with a response scoreboard and a behavioural mult/div unit.
// Latency: checks accept->response timing per operation type.
// Backpressure: exercises held responses and requests waiting while busy.
module tb_multdiv_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_sched_if bus();
  multdiv_sched #(.MULT_LAT(2)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [3:0]  ctl_hist [0:63];
  logic [1:0]  g_exp [0:3];

  // Behavioural unit: stall counts down after a divide issue, results read by ctl code.
  int          div_stall = 0;
  int          stall_cnt = 0;
  logic        unit_div = 1'b0;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mdu_ctl_o == 4'b1101) stall_cnt <= div_stall;
    else if (stall_cnt > 0)       stall_cnt <= stall_cnt - 1;
    if (bus.mdu_ctl_o[3:1] == 3'b110) unit_div <= bus.mdu_ctl_o[0];
  end

  always_comb begin
    prod = $signed({{32{bus.mdu_op1_o[31]}}, bus.mdu_op1_o}) * $signed({{32{bus.mdu_op2_o[31]}}, bus.mdu_op2_o});
    if (bus.mdu_op2_o == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = bus.mdu_op1_o;
    end else begin
      quo = $signed(bus.mdu_op1_o) / $signed(bus.mdu_op2_o);
      rem = $signed(bus.mdu_op1_o) % $signed(bus.mdu_op2_o);
    end
    res = 32'd0;
    if (bus.mdu_ctl_o == 4'b1001) res = unit_div ? quo : prod[31:0];
    if (bus.mdu_ctl_o == 4'b1000) res = unit_div ? rem : prod[63:32];
  end

  assign bus.mdu_stall_i = (stall_cnt != 0);
  assign bus.mdu_res_i   = res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops the next expected result.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && ((bus.rsp_valid_o & bus.rsp_ready_i) != 2'b00)) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got valid %b with no expected response", bus.rsp_valid_o);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(e.vld));
        chk("rsp_hi", bus.rsp_hi_o, e.hi);
        chk("rsp_lo", bus.rsp_lo_o, e.lo);
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, "_ctl"}, 32'(bus.mdu_ctl_o), 32'd0);
    chk({tag, "_op1"}, bus.mdu_op1_o, 32'd0);
    chk({tag, "_op2"}, bus.mdu_op2_o, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic drive_req(input int id, input logic dv, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_i[id] = 1'b1;
    bus.req_div_i[id]   = dv;
    if (id == 1) begin
      bus.req_a_i[63:32] = a;
      bus.req_b_i[63:32] = b;
    end else begin
      bus.req_a_i[31:0] = a;
      bus.req_b_i[31:0] = b;
    end
  endtask

  // Issue one request, then check accept, operand hold, response timing and quiet unit port in RESP.
  task automatic run_op(input int id, input logic dv, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int stall,
                        input int exp_lat, input string tag);
    int t0;
    int lat;
    bit ok;
    bit stable;
    exp_t e;
    e.vld = (id == 1) ? 2'b10 : 2'b01;
    e.hi  = hi;
    e.lo  = lo;
    div_stall = stall;
    sb_q.push_back(e);
    @(negedge clk);
    drive_req(id, dv, a, b);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready_o[id]) ok = 1'b1;
    end
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      bus.req_valid_i[id] = 1'b0;
      return;
    end
    t0 = cyc;
    bus.req_valid_i[id] = 1'b0;
    for (int k = 0; k < 64; k++) ctl_hist[k] = 4'hF;
    ctl_hist[0] = bus.mdu_ctl_o;
    chk({tag, "_issue_op1"}, bus.mdu_op1_o, a);
    chk({tag, "_issue_op2"}, bus.mdu_op2_o, b);
    ok = 1'b0;
    stable = 1'b1;
    lat = 0;
    for (int k = 1; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (k < 64) ctl_hist[k] = bus.mdu_ctl_o;
      if (bus.rsp_valid_o[id]) begin
        ok  = 1'b1;
        lat = cyc - t0;
      end else if ((bus.mdu_op1_o !== a) || (bus.mdu_op2_o !== b)) begin
        stable = 1'b0;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_ops_stable"}, 32'(stable), 32'd1);
    chk({tag, "_resp_unit_idle"}, 32'(bus.mdu_ctl_o) | bus.mdu_op1_o | bus.mdu_op2_o, 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int g;
    int c0;
    int c1;
    bit ok;
    bit hold_ok;
    bit wait_ok;
    exp_t e;

    bus.req_valid_i = 2'b00;
    bus.req_div_i   = 2'b00;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 2'b11;
    g_exp[0] = 2'b01;
    g_exp[1] = 2'b10;
    g_exp[2] = 2'b01;
    g_exp[3] = 2'b10;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_hi", bus.rsp_hi_o, 32'd0);
    chk("reset_lo", bus.rsp_lo_o, 32'd0);
    rst_n = 1'b1;

    // Multiply 7 * -3 = -21; ctl sequence 1100, wait, wait, 1001, 1000; response at T+5.
    run_op(0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 5, "mul7x-3");
    chk("mul_ctl_t0", 32'(ctl_hist[0]), 32'hC);
    chk("mul_ctl_t1", 32'(ctl_hist[1]), 32'h0);
    chk("mul_ctl_t2", 32'(ctl_hist[2]), 32'h0);
    chk("mul_ctl_t3", 32'(ctl_hist[3]), 32'h9);
    chk("mul_ctl_t4", 32'(ctl_hist[4]), 32'h8);

    // Lone requester 0 granted although the pointer now favours requester 1: -100/7 = -14 rem -2.
    run_op(0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 3, 7, "div-100/7");
    chk("div_ctl_t0", 32'(ctl_hist[0]), 32'hD);

    // Requester 1 divide with 31 stall cycles: 100/7 = 14 rem 2.
    run_op(1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 31, 35, "div100/7");

    // Divide by zero reaches the unit untouched.
    run_op(0, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 6, "div5/0");

    // Held response: 0x10000 * 0x10000 = 2^32, another request must wait.
    @(negedge clk);
    bus.rsp_ready_i = 2'b00;
    run_op(1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 0, 5, "hold_mul");
    drive_req(0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
    hold_ok = 1'b1;
    wait_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((bus.rsp_valid_o !== 2'b10) || (bus.rsp_hi_o !== 32'd1) || (bus.rsp_lo_o !== 32'd0)) hold_ok = 1'b0;
      if ((bus.req_ready_o !== 2'b00) || (bus.busy_o !== 1'b1)) wait_ok = 1'b0;
    end
    chk("hold_rsp_stable", 32'(hold_ok), 32'd1);
    chk("hold_no_grant_busy", 32'(wait_ok), 32'd1);
    bus.rsp_ready_i = 2'b11;
    run_op(0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0, 32'd30, 0, 5, "after_hold");

    // Both requesting across reset release: grants alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(0, 1'b0, 32'd3, 32'd4);
    drive_req(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    div_stall = 1;
    e.vld = 2'b01; e.hi = 32'd0; e.lo = 32'd12;          sb_q.push_back(e);
    e.vld = 2'b10; e.hi = 32'd0; e.lo = 32'd1;           sb_q.push_back(e);
    e.vld = 2'b01; e.hi = 32'd1; e.lo = 32'd4;           sb_q.push_back(e);
    e.vld = 2'b10; e.hi = 32'd0; e.lo = 32'hFFFF_FFFE;   sb_q.push_back(e);
    repeat (2) @(negedge clk);
    chk_quiet("rr_reset");
    rst_n = 1'b1;
    g = 0;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 400 && g < 4; k++) begin
      @(negedge clk);
      if (bus.req_ready_o != 2'b00) begin
        chk($sformatf("rr_grant%0d", g), 32'(bus.req_ready_o), 32'(g_exp[g]));
        if (bus.req_ready_o[0]) begin
          c0++;
          if (c0 == 1) drive_req(0, 1'b1, 32'd9, 32'd2);
          else         bus.req_valid_i[0] = 1'b0;
        end else begin
          c1++;
          if (c1 == 1) drive_req(1, 1'b0, 32'h7FFF_FFFF, 32'd2);
          else         bus.req_valid_i[1] = 1'b0;
        end
        g++;
      end
    end
    chk("rr_grant_count", g, 4);
    bus.req_valid_i = 2'b00;
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("rr_drained", sb_q.size(), 0);

    // Reset during divide WAIT abandons the operation; the reissue completes.
    repeat (2) @(negedge clk);
    div_stall = 20;
    drive_req(0, 1'b1, 32'd1000, 32'd10);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready_o[0]) ok = 1'b1;
    end
    chk("abort_accept", 32'(ok), 32'd1);
    bus.req_valid_i[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_in_wait", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
    chk("abort_hi", bus.rsp_hi_o, 32'd0);
    chk("abort_lo", bus.rsp_lo_o, 32'd0);
    rst_n = 1'b1;
    run_op(0, 1'b1, 32'd1000, 32'd10, 32'd0, 32'd100, 20, 24, "reissue");

    // Repeated multiply: with the result cache it is answered from the cache.
    run_op(0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 5, "rep_first");
`ifdef MULTDIV_SCHED_REUSE_EN
    run_op(0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1, "rep_hit");
    chk("rep_hit_ctl_t0", 32'(ctl_hist[0]), 32'h0);
`else
    run_op(0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 5, "rep_again");
    chk("rep_again_ctl_t0", 32'(ctl_hist[0]), 32'hC);
    chk("rep_again_ctl_t3", 32'(ctl_hist[3]), 32'h9);
`endif

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
